// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI slave bridge.
package spi_pkg;

    // Frame-level state of the slave.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHK_CMD,
        ST_WRITE,
        ST_READ_ADD,
        ST_READ_DATA,
        ST_WAIT_TX,
        ST_SEND,
        ST_DONE
    } state_t;

    // Two most significant command bits of every frame.
    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    // Full serial frame width: command prefix followed by payload.
    function automatic int frame_w(input int cmd_w, input int data_w);
        return cmd_w + data_w;
    endfunction

endpackage

// File: rtl/spi_slave_gen_if.sv
// SPI pins plus the parallel RAM-side handshake, bundled for the slave.
interface spi_slave_gen_if
    import spi_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CMD_W  = 2
);
    localparam int FRAME_W = frame_w(CMD_W, DATA_W);

    logic               SS_n;
    logic               MOSI;
    logic               MISO;
    logic [FRAME_W-1:0] rx_data;
    logic               rx_valid;
    logic [DATA_W-1:0]  tx_data;
    logic               tx_valid;

    modport slave (
        input  SS_n, MOSI, tx_data, tx_valid,
        output MISO, rx_data, rx_valid
    );

    modport master (
        output SS_n, MOSI, tx_data, tx_valid,
        input  MISO, rx_data, rx_valid
    );
endinterface

// File: rtl/spi_tx_shifter.sv
// Read-data serialiser: loads a RAM word and presents it MSB first on MISO.
module spi_tx_shifter #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              shift_en,
    input  logic              clear,
    input  logic [DATA_W-1:0] data,
    output logic              miso
);
    // Bits still waiting to go out; the current bit already sits in miso.
    logic [DATA_W-2:0] rest;

    // Clear wins over load, load wins over shift.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking assignments let every flop sample the old value of
        // its neighbours, which is what makes this a shift register.
        if (!rst_n) begin
            rest <= '0;
            miso <= 1'b0;
        end else if (clear) begin
            rest <= '0;
            miso <= 1'b0;
        end else if (load) begin
            rest <= data[DATA_W-2:0];
            miso <= data[DATA_W-1];
        end else if (shift_en) begin
            miso <= rest[DATA_W-2];
            rest <= {rest[DATA_W-3:0], 1'b0};
        end
    end
endmodule

// File: rtl/spi_slave_gen.sv
// SPI slave: deserialises command frames for the RAM controller and
// serialises read data back on MISO after the tx_valid handshake.
module spi_slave_gen
    import spi_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CMD_W  = 2
) (
    input logic            clk,
    input logic            rst_n,
    spi_slave_gen_if.slave bus
);
    localparam int FRAME_W = frame_w(CMD_W, DATA_W);
    localparam int CNT_W   = $clog2(FRAME_W);
    localparam logic [CNT_W-1:0] RX_LAST = CNT_W'(FRAME_W - 1);
    localparam logic [CNT_W-1:0] TX_LAST = CNT_W'(DATA_W);

    state_t             state;
    state_t             state_next;
    logic [FRAME_W-2:0] rx_shreg;
    logic [CNT_W-1:0]   cnt;
    logic               rd_addr_seen;
    logic [FRAME_W-1:0] rx_data_q;
    logic               rx_valid_q;
    logic               miso;

    // Control strobes produced by the output decoder.
    logic rx_sample;
    logic frame_done;
    logic seen_set;
    logic seen_clr;
    logic cnt_clr;
    logic cnt_one;
    logic cnt_inc;
    logic tx_load;
    logic tx_shift;
    logic tx_clear;

    logic rx_last;
    logic tx_last;

    assign rx_last = (cnt == RX_LAST);
    assign tx_last = (cnt == TX_LAST);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    // Next-state decode; a completing frame finishes even if SS_n rises with it.
    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE: begin
                if (!bus.SS_n) state_next = ST_CHK_CMD;
            end
            ST_CHK_CMD: begin
                if (bus.SS_n)                        state_next = ST_IDLE;
                else if (bus.MOSI != CMD_RD_ADDR[1]) state_next = ST_WRITE;
                else if (rd_addr_seen)               state_next = ST_READ_DATA;
                else                                 state_next = ST_READ_ADD;
            end
            ST_WRITE, ST_READ_ADD, ST_READ_DATA: begin
                if (rx_last) begin
                    if (bus.SS_n)                  state_next = ST_IDLE;
                    else if (state == ST_READ_DATA) state_next = ST_WAIT_TX;
                    else                           state_next = ST_DONE;
                end else if (bus.SS_n) begin
                    state_next = ST_IDLE;
                end
            end
            ST_WAIT_TX: begin
                if (bus.SS_n)          state_next = ST_IDLE;
                else if (bus.tx_valid) state_next = ST_SEND;
            end
            ST_SEND: begin
                if (bus.SS_n)    state_next = ST_IDLE;
                else if (tx_last) state_next = ST_DONE;
            end
            ST_DONE: begin
                if (bus.SS_n) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Output decode: datapath strobes for the current state and inputs.
    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves
        // one unassigned, which would otherwise infer a latch.
        rx_sample  = 1'b0;
        frame_done = 1'b0;
        seen_set   = 1'b0;
        seen_clr   = 1'b0;
        cnt_clr    = 1'b0;
        cnt_one    = 1'b0;
        cnt_inc    = 1'b0;
        tx_load    = 1'b0;
        tx_shift   = 1'b0;
        tx_clear   = 1'b0;
        unique case (state)
            ST_IDLE: begin
                cnt_clr  = 1'b1;
                tx_clear = 1'b1;
            end
            ST_CHK_CMD: begin
                if (bus.SS_n) begin
                    cnt_clr = 1'b1;
                end else begin
                    rx_sample = 1'b1;
                    cnt_one   = 1'b1;
                end
            end
            ST_WRITE, ST_READ_ADD, ST_READ_DATA: begin
                if (rx_last) begin
                    frame_done = 1'b1;
                    cnt_clr    = 1'b1;
                    seen_set   = (state == ST_READ_ADD);
                    seen_clr   = (state == ST_READ_DATA);
                end else if (bus.SS_n) begin
                    cnt_clr = 1'b1;
                end else begin
                    rx_sample = 1'b1;
                    cnt_inc   = 1'b1;
                end
            end
            ST_WAIT_TX: begin
                if (bus.SS_n) begin
                    cnt_clr  = 1'b1;
                    tx_clear = 1'b1;
                end else if (bus.tx_valid) begin
                    tx_load = 1'b1;
                    cnt_one = 1'b1;
                end
            end
            ST_SEND: begin
                if (bus.SS_n || tx_last) begin
                    cnt_clr  = 1'b1;
                    tx_clear = 1'b1;
                end else begin
                    tx_shift = 1'b1;
                    cnt_inc  = 1'b1;
                end
            end
            ST_DONE: begin
                cnt_clr  = 1'b1;
                tx_clear = 1'b1;
            end
            default: begin
                cnt_clr  = 1'b1;
                tx_clear = 1'b1;
            end
        endcase
    end

    // Receive datapath: shift register, bit counter, frame output, read flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_shreg     <= '0;
            cnt          <= '0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            rd_addr_seen <= 1'b0;
        end else begin
            rx_valid_q <= frame_done;
            if (rx_sample) rx_shreg <= {rx_shreg[FRAME_W-3:0], bus.MOSI};
            if (frame_done) rx_data_q <= {rx_shreg, bus.MOSI};

            if (cnt_clr)      cnt <= '0;
            else if (cnt_one) cnt <= CNT_W'(1);
            else if (cnt_inc) cnt <= cnt + CNT_W'(1);

            if (seen_set)      rd_addr_seen <= 1'b1;
            else if (seen_clr) rd_addr_seen <= 1'b0;
        end
    end

    spi_tx_shifter #(.DATA_W(DATA_W)) u_tx_shifter (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tx_load),
        .shift_en (tx_shift),
        .clear    (tx_clear),
        .data     (bus.tx_data),
        .miso     (miso)
    );

    assign bus.MISO     = miso;
    assign bus.rx_data  = rx_data_q;
    assign bus.rx_valid = rx_valid_q;
endmodule

// File: tb/tb_spi_slave_gen.sv
// Self-checking bench for spi_slave_gen: directed cases plus randomized frames
// against a frame-level reference model (DATA_W=8), and a DATA_W=16 instance.
module tb_spi_slave_gen;
    import spi_pkg::*;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    spi_slave_gen_if #(.DATA_W(8),  .CMD_W(2)) bus8 ();
    spi_slave_gen_if #(.DATA_W(16), .CMD_W(2)) bus16 ();

    spi_slave_gen #(.DATA_W(8), .CMD_W(2)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus8)
    );

    spi_slave_gen #(.DATA_W(16), .CMD_W(2)) dut16 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus16)
    );

    int n_checks = 0;
    int n_errors = 0;
    bit m_seen   = 1'b0;   // model of the "read address already received" flag

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One 10-bit frame on the 8-bit slave.
    // mode 0: complete frame; 1: SS_n rises after abort_bits bits; 2: SS_n rises with last bit.
    task automatic run_frame(input logic [1:0] cmd, input logic [7:0] payload, input int mode,
                             input int abort_bits, input int tx_delay, input int send_abort,
                             input logic [7:0] txv);
        logic [9:0] frame;
        bit         rb;
        int         nshow;
        frame = {cmd, payload};
        rb    = 1'b0;
        bus8.SS_n = 1'b0;
        tick();                                   // t0
        if (mode == 1) begin
            for (int k = 0; k < abort_bits; k++) begin
                bus8.MOSI = frame[9-k];
                tick();
                check("rx_valid_partial", bus8.rx_valid, 0);
                check("miso_partial", bus8.MISO, 0);
            end
            bus8.SS_n = 1'b1;
            bus8.MOSI = 1'($urandom);
            tick();
            check("rx_valid_abort", bus8.rx_valid, 0);
            check("miso_abort", bus8.MISO, 0);
            check("rd_addr_seen_abort", dut8.rd_addr_seen, m_seen);
            return;
        end
        for (int k = 0; k < 10; k++) begin
            bus8.MOSI = frame[9-k];
            if (k == 9) begin
                bus8.tx_valid = 1'b1;            // must be ignored at t(FRAME_W)
                bus8.tx_data  = ~txv;
                if (mode == 2) bus8.SS_n = 1'b1;
            end
            tick();
            check("miso_frame", bus8.MISO, 0);
            if (k < 9) check("rx_valid_early", bus8.rx_valid, 0);
        end
        bus8.tx_valid = 1'b0;
        check("rx_valid_pulse", bus8.rx_valid, 1);
        check("rx_data", bus8.rx_data, frame);
        if (cmd[1]) begin
            if (m_seen) begin
                rb     = (mode != 2);
                m_seen = 1'b0;
            end else begin
                m_seen = 1'b1;
            end
        end
        if (mode == 2) begin
            tick();
            check("rx_valid_once", bus8.rx_valid, 0);
            check("miso_ss_last", bus8.MISO, 0);
            check("rd_addr_seen", dut8.rd_addr_seen, m_seen);
            return;
        end
        for (int d = 0; d < tx_delay; d++) begin
            tick();
            check("rx_valid_once", bus8.rx_valid, 0);
            check("miso_wait", bus8.MISO, 0);
        end
        bus8.tx_valid = 1'b1;
        bus8.tx_data  = txv;
        tick();                                   // tv
        bus8.tx_valid = 1'b0;
        bus8.tx_data  = 8'($urandom);
        check("rx_valid_once", bus8.rx_valid, 0);
        if (rb) begin
            nshow = (send_abort > 0) ? send_abort : 8;
            check("miso_bit", bus8.MISO, txv[7]);
            for (int j = 1; j < nshow; j++) begin
                tick();
                check("miso_bit", bus8.MISO, txv[7-j]);
            end
            if (send_abort == 0) begin
                tick();
                check("miso_after_send", bus8.MISO, 0);
                tick();
                check("miso_done", bus8.MISO, 0);
            end
        end else begin
            check("miso_no_read", bus8.MISO, 0);
        end
        bus8.SS_n = 1'b1;
        tick();
        check("miso_idle", bus8.MISO, 0);
        check("rd_addr_seen", dut8.rd_addr_seen, m_seen);
        check("rx_valid_idle", bus8.rx_valid, 0);
    endtask

    // Write-data frame on the 16-bit slave.
    task automatic frame16(input logic [15:0] payload);
        logic [17:0] frame;
        frame = {CMD_WR_DATA, payload};
        bus16.SS_n = 1'b0;
        tick();
        for (int k = 0; k < 18; k++) begin
            bus16.MOSI = frame[17-k];
            tick();
            if (k < 17) check("rx16_valid_early", bus16.rx_valid, 0);
            check("miso16", bus16.MISO, 0);
        end
        check("rx16_valid_pulse", bus16.rx_valid, 1);
        check("rx16_data", bus16.rx_data, frame);
        bus16.SS_n = 1'b1;
        tick();
        check("rx16_valid_once", bus16.rx_valid, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [1:0] cmd;
        int         r;
        int         mode;

        bus8.SS_n  = 1'b1; bus8.MOSI  = 1'b0; bus8.tx_valid  = 1'b0; bus8.tx_data  = '0;
        bus16.SS_n = 1'b1; bus16.MOSI = 1'b0; bus16.tx_valid = 1'b0; bus16.tx_data = '0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        tick();
        tick();
        check("reset_miso", bus8.MISO, 0);
        check("reset_rx_data", bus8.rx_data, 0);
        check("reset_rx_valid", bus8.rx_valid, 0);
        check("reset_rd_addr_seen", dut8.rd_addr_seen, 0);
        @(negedge clk) rst_n = 1'b1;
        tick();

        // Directed cases.
        run_frame(CMD_WR_ADDR, 8'hA5, 0, 0, 0, 0, 8'h00);
        run_frame(CMD_WR_DATA, 8'h3C, 0, 0, 0, 0, 8'h00);
        run_frame(CMD_WR_DATA, 8'h3C, 0, 0, 0, 0, 8'h00);
        run_frame(CMD_RD_ADDR, 8'h07, 0, 0, 0, 0, 8'h00);
        check("rd_addr_seen_set", dut8.rd_addr_seen, 1);
        run_frame(CMD_RD_DATA, 8'h5E, 0, 0, 3, 0, 8'hC3);
        check("rd_addr_seen_clr", dut8.rd_addr_seen, 0);
        run_frame(CMD_WR_DATA, 8'h81, 1, 5, 0, 0, 8'h00);
        run_frame(CMD_WR_ADDR, 8'h42, 0, 0, 0, 0, 8'h00);
        run_frame(CMD_RD_ADDR, 8'h10, 0, 0, 0, 0, 8'h00);
        run_frame(CMD_RD_DATA, 8'h00, 0, 0, 1, 3, 8'hA6);
        check("rd_addr_seen_send_abort", dut8.rd_addr_seen, 0);
        run_frame(CMD_WR_DATA, 8'h99, 2, 0, 0, 0, 8'h00);
        run_frame(CMD_RD_DATA, 8'hFF, 0, 0, 0, 0, 8'h7E);   // no read address yet: acts as address

        // Randomized frames.
        for (int i = 0; i < 40; i++) begin
            cmd  = 2'($urandom_range(0, 3));
            r    = $urandom_range(0, 9);
            mode = (r < 2) ? 1 : ((r < 3 && !cmd[1]) ? 2 : 0);
            run_frame(cmd, 8'($urandom), mode, $urandom_range(0, 8), $urandom_range(0, 4),
                      ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0, 8'($urandom));
            for (int g = 0; g < $urandom_range(0, 2); g++) tick();
        end

        // Reset mid-frame after a read address was seen.
        run_frame(CMD_RD_ADDR, 8'h5A, 0, 0, 0, 0, 8'h00);
        bus8.SS_n = 1'b0;
        tick();
        for (int k = 0; k < 5; k++) begin
            bus8.MOSI = 1'b1;
            tick();
        end
        #2 rst_n = 1'b0;
        #1;
        check("midreset_rx_data", bus8.rx_data, 0);
        check("midreset_rx_valid", bus8.rx_valid, 0);
        check("midreset_miso", bus8.MISO, 0);
        check("midreset_rd_addr_seen", dut8.rd_addr_seen, 0);
        m_seen = 1'b0;
        bus8.SS_n = 1'b1;
        @(negedge clk) rst_n = 1'b1;
        tick();
        run_frame(CMD_RD_DATA, 8'h33, 0, 0, 0, 0, 8'hF0);   // acts as address after reset

        // Reset while MISO is driving a 1.
        bus8.SS_n = 1'b0;
        tick();
        for (int k = 0; k < 10; k++) begin
            bus8.MOSI = 1'b1;
            tick();
        end
        bus8.tx_valid = 1'b1;
        bus8.tx_data  = 8'hFF;
        tick();
        bus8.tx_valid = 1'b0;
        check("send_pre_reset_miso", bus8.MISO, 1);
        #2 rst_n = 1'b0;
        #1;
        check("send_reset_miso", bus8.MISO, 0);
        check("send_reset_rx_data", bus8.rx_data, 0);
        m_seen = 1'b0;
        bus8.SS_n = 1'b1;
        @(negedge clk) rst_n = 1'b1;
        tick();

        // Wider payload instance.
        frame16(16'hBEEF);
        check("rx16_beef", bus16.rx_data, 18'h1BEEF);
        for (int i = 0; i < 3; i++) frame16(16'($urandom));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/spi_slave_gen.md
# spi_slave_gen

Parametrised system-synchronous SPI slave bridging an external SPI master to the on-chip single-port RAM controller. It deserialises command-prefixed frames into parallel words for the RAM (`rx_data`/`rx_valid`). It returns read data by serialising the RAM's `tx_data` onto MISO after a `tx_valid` handshake. It replaces the fixed 10-bit slave with configurable widths, a real bit counter, and a defined read-back sequence.

## Interface
- `DATA_W`, 8, payload width (address or data byte)
- `CMD_W`, 2, command prefix width; frame width `FRAME_W = CMD_W + DATA_W`
- `clk`  in  1  system clock; SPI bit clock equals `clk`
- `rst_n`  in  1  reset, asynchronous, active-low
- `SS_n`  in  1  slave select, active-low; frame framing
- `MOSI`  in  1  serial in, MSB first, sampled on rising `clk`
- `MISO`  out  1  serial out, MSB first, registered
- `rx_data`  out  FRAME_W  received frame: `{cmd, payload}`
- `rx_valid`  out  1  one-cycle pulse, `rx_data` valid
- `tx_data`  in  DATA_W  read data from RAM
- `tx_valid`  in  1  `tx_data` valid; sampled only while awaiting read data

## Operation
- Commands are `cmd[CMD_W-1:CMD_W-2]`:
  - `00` = write address
  - `01` = write data
  - `10` = read address
  - `11` = read data
- Remaining cmd bits, if any, are passed through in `rx_data`.
- States: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA, WAIT_TX, SEND, DONE.
- IDLE → CHK_CMD when `SS_n`=0.
- CHK_CMD samples frame bit 0 (cmd MSB) into the shift register:
  - bit 0 = 0 → WRITE.
  - bit 0 = 1 and `rd_addr_seen`=0 → READ_ADD.
  - bit 0 = 1 and `rd_addr_seen`=1 → READ_DATA.
- WRITE, READ_ADD and READ_DATA shift in the remaining `FRAME_W-1` bits. The bit counter is `$clog2(FRAME_W)` wide and counts from 1 up to `FRAME_W-1`.
- On the last bit, the state loads `rx_data` with the full frame and pulses `rx_valid`, then moves as follows:
  - WRITE → DONE.
  - READ_ADD → DONE; sets `rd_addr_seen`.
  - READ_DATA → WAIT_TX; clears `rd_addr_seen`.
- WAIT_TX: on an edge with `tx_valid`=1, capture `tx_data` into the tx shifter, drive its MSB on MISO, then go to SEND.
- SEND: shift out the remaining `DATA_W-1` bits, one per cycle, then go to DONE.
- DONE: ignore MOSI; hold MISO=0 until `SS_n`=1.
- `SS_n`=1 in any non-IDLE state → IDLE on the next edge:
  - partial frame discarded; no `rx_valid`
  - MISO=0
  - bit counter cleared
  - `rd_addr_seen` unchanged
- `rd_addr_seen` is cleared only by reset or by a completed read-data frame.
- The host's cmd bits are not cross-checked against `rd_addr_seen`. `rx_data` always carries what was received.

## Timing
- Reset values: state IDLE, `MISO`=0, `rx_data`=0, `rx_valid`=0, `rd_addr_seen`=0.
- Let t0 be the edge on which IDLE sees `SS_n`=0. Frame bit k is sampled at edge t(k+1).
- `rx_data`/`rx_valid` update at edge t(FRAME_W). `rx_valid` is high for exactly one cycle.
- Read-back latency: the MISO MSB appears at the first edge ≥ t(FRAME_W+1) with `tx_valid`=1. The last bit is held from edge tv+DATA_W−1 until the next edge.
- `tx_valid` outside WAIT_TX is ignored, including at t(FRAME_W) itself.
- `SS_n` rising on the same edge as the last frame bit: the frame completes (`rx_valid` pulses), then the state goes to IDLE.
- `SS_n` rising during SEND aborts the transmission; MISO=0 on the next cycle.
- Reset mid-frame: all outputs return to reset values asynchronously.

## Structure
- Package `spi_pkg` holds:
  - state enum
  - cmd code constants (`CMD_WR_ADDR`, `CMD_WR_DATA`, `CMD_RD_ADDR`, `CMD_RD_DATA`)
  - `FRAME_W` derivation function
- One sub-module, `spi_tx_shifter`, parametrised by `DATA_W`:
  - inputs: load, shift enable, clear
  - output: registered MISO bit
- The FSM, rx shift register and bit counter stay in the top module.

## Test plan
- Write address, defaults: `SS_n` low, MOSI `00_1010_0101` → `rx_data`=10'h0A5, `rx_valid` 1 cycle at t10, MISO stays 0.
- Write data: MOSI `01_0011_1100` → `rx_data`=10'h13C; second identical frame after `SS_n` toggle → second pulse.
- Read sequence:
  - Send `10_0000_0111`; `rd_addr_seen`=1.
  - Send `11_xxxx_xxxx`, then `tx_valid` pulse with `tx_data`=8'hC3 three cycles later.
  - Required: MISO = 1,1,0,0,0,0,1,1 on consecutive cycles, then 0; `rd_addr_seen`=0.
- Abort: `SS_n` high after 5 bits → no `rx_valid`; the next full frame decodes correctly.
- Abort during SEND after 3 bits → MISO 0 next cycle; `rd_addr_seen` stays 0.
- Parameter sweep `DATA_W`=16, `CMD_W`=2: write data 16'hBEEF → `rx_data`=18'h1BEEF at t18.
